// File: rtl/led_pattern_arbiter_pkg.sv
// Shared types for the LED pattern arbiter.
// Holds FSM states, requester/pattern sizes and the round-robin picker.
package led_pattern_arbiter_pkg;

   localparam int NUM_REQ  = 4;
   localparam int PAT_BITS = 8;

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      GAP
   } state_t;

   // Searches ptr+1, ptr+2, ptr+3, ptr (mod 4)
   // and returns the first requesting index.
   function automatic logic [1:0] rr_pick(
      input logic [NUM_REQ-1:0] req,
      input logic [1:0]         ptr
   );
      logic [1:0] idx;
      logic [1:0] win;
      logic       found;
      win   = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/led_pattern_arbiter_if.sv
// Request/pattern/grant bundle of the LED pattern arbiter.
// Ports: REQ, PAT (to arbiter); GNT, DONE, BUSY, LED (from arbiter).
interface led_pattern_arbiter_if;
   import led_pattern_arbiter_pkg::*;

   logic [NUM_REQ-1:0]          REQ;
   logic [NUM_REQ*PAT_BITS-1:0] PAT;
   logic [NUM_REQ-1:0]          GNT;
   logic [NUM_REQ-1:0]          DONE;
   logic                        BUSY;
   logic                        LED;

   modport master (
      output REQ, PAT,
      input  GNT, DONE, BUSY, LED
   );

   modport slave (
      input  REQ, PAT,
      output GNT, DONE, BUSY, LED
   );

endinterface

// File: rtl/led_pattern_arbiter_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_TICK-1, tick on terminal count.
// Ports: CLK, RST_N (async low), clr (hold at 0), tick (out).
module tick_gen #(
   parameter int CLKS_PER_TICK = 1200000
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic clr,
   output logic tick
);

   localparam int W = $clog2(CLKS_PER_TICK);
   localparam logic [W-1:0] LAST = W'(CLKS_PER_TICK - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q <= '0;
      end else if (clr || cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/led_pattern_arbiter.sv
// Round-robin arbiter playing one requester's 8-bit pattern on a shared LED.
// Ports: CLK, RST_N (async low), bus (slave: REQ/PAT in, GNT/DONE/BUSY/LED out).
module led_pattern_arbiter
   import led_pattern_arbiter_pkg::*;
#(
   parameter int CLKS_PER_TICK = 1200000
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   led_pattern_arbiter_if.slave bus
);

   localparam logic [2:0] LAST_BIT = 3'(PAT_BITS - 1);

   state_t              state_q, state_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [NUM_REQ-1:0]  done_q, done_d;
   logic                led_q, led_d;
   logic [PAT_BITS-1:0] pat_q, pat_d;
   logic [2:0]          idx_q, idx_d;
   logic [1:0]          ptr_q, ptr_d;
   logic [1:0]          own_q, own_d;
   logic [1:0]          win;
   logic                clr;
   logic                tick;

   tick_gen #(
      .CLKS_PER_TICK(CLKS_PER_TICK)
   ) u_tick (
      .CLK  (CLK),
      .RST_N(RST_N),
      .clr  (clr),
      .tick (tick)
   );

   assign win = rr_pick(bus.REQ, ptr_q);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      led_d   = led_q;
      pat_d   = pat_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      own_d   = own_q;
      clr     = 1'b0;
      unique case (state_q)
         IDLE: begin
            clr   = 1'b1;
            led_d = 1'b0;
            gnt_d = '0;
            if (|bus.REQ) begin
               state_d = PLAY;
               own_d   = win;
               gnt_d   = NUM_REQ'(1) << win;
               pat_d   = bus.PAT[{win, 3'b000} +: PAT_BITS];
               idx_d   = '0;
               led_d   = pat_d[0];
            end
         end
         PLAY: begin
            if (tick) begin
               if (idx_q == LAST_BIT) begin
                  state_d = GAP;
                  gnt_d   = '0;
                  done_d  = gnt_q;
                  led_d   = 1'b0;
                  ptr_d   = own_q;
               end else begin
                  idx_d = idx_q + 3'd1;
                  led_d = pat_q[idx_d];
               end
            end
         end
         GAP: begin
            led_d = 1'b0;
            if (tick) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            led_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         done_q  <= '0;
         led_q   <= 1'b0;
         pat_q   <= '0;
         idx_q   <= '0;
         ptr_q   <= 2'd3;
         own_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         led_q   <= led_d;
         pat_q   <= pat_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         own_q   <= own_d;
      end
   end

   assign bus.GNT  = gnt_q;
   assign bus.DONE = done_q;
   assign bus.LED  = led_q;
   assign bus.BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Bench for led_pattern_arbiter with CLKS_PER_TICK=4.
// Expected playbacks are queued by stimulus and checked by a DONE monitor.
module tb_led_pattern_arbiter;

   localparam int CPT = 4;

   typedef struct {
      logic [3:0] gnt;
      logic [7:0] pat;
   } exp_t;

   logic CLK;
   logic RST_N;
   int   checks;
   int   errors;
   int   cyc;
   exp_t exp_q[$];

   led_pattern_arbiter_if bus();

   led_pattern_arbiter #(
      .CLKS_PER_TICK(CPT)
   ) dut (
      .CLK  (CLK),
      .RST_N(RST_N),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc++;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   // Monitor: captures each playback from GNT rise and scores it on DONE.
   logic       active;
   logic       gap_on;
   logic       gap_bad;
   int         gap_n;
   int         t0;
   int         ntr;
   logic [3:0] g0;
   logic       tr[64];

   initial begin
      active = 0;
      gap_on = 0;
      gap_bad = 0;
      gap_n = 0;
      ntr = 0;
      t0 = 0;
      g0 = '0;
   end

   always @(negedge CLK) begin
      if (!RST_N) begin
         active = 0;
         gap_on = 0;
      end else begin
         if (bus.GNT != 0) begin
            if (!active) begin
               active = 1;
               t0 = cyc;
               g0 = bus.GNT;
               ntr = 0;
            end
            if (ntr < 64) tr[ntr] = bus.LED;
            ntr++;
         end
         if (bus.DONE != 0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'(bus.DONE), 32'h0);
            end else begin
               exp_t e;
               int bad;
               e = exp_q.pop_front();
               bad = 0;
               chk("done_vec", 32'(bus.DONE), 32'(e.gnt));
               chk("gnt_owner", 32'(g0), 32'(e.gnt));
               chk("gnt_to_done", 32'(cyc - t0), 32'(8 * CPT));
               chk("gnt_len", 32'(ntr), 32'(8 * CPT));
               for (int k = 0; k < 8 * CPT; k++)
                  if (tr[k] !== e.pat[k / CPT]) bad++;
               chk("led_trace", 32'(bad), 32'h0);
            end
            active = 0;
            gap_on = 1;
            gap_n = 0;
            gap_bad = 0;
         end
         if (gap_on) begin
            if (bus.BUSY) begin
               gap_n++;
               if (bus.LED !== 1'b0 || bus.GNT !== 4'h0)
                  gap_bad = 1;
            end else begin
               chk("gap_len", 32'(gap_n), 32'(CPT));
               chk("gap_led", 32'(gap_bad), 32'h0);
               gap_on = 0;
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic wait_idle(input int bound);
      logic ok;
      ok = 0;
      for (int i = 0; i < bound; i++) begin
         step();
         if (exp_q.size() == 0 && !bus.BUSY) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("idle_timeout", 32'h1, 32'h0);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [3:0] pg;
      checks = 0;
      errors = 0;
      cyc = 0;
      RST_N = 1'b0;
      bus.REQ = '0;
      bus.PAT = '0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_gnt", 32'(bus.GNT), 32'h0);
      chk("rst_done", 32'(bus.DONE), 32'h0);
      chk("rst_led", 32'(bus.LED), 32'h0);
      chk("rst_busy", 32'(bus.BUSY), 32'h0);
      step();
      RST_N = 1'b1;
      step();

      // Contention: all four request, order 0,1,2,3,0
      bus.PAT = {8'h81, 8'h42, 8'h24, 8'h18};
      exp_q.push_back('{4'b0001, 8'h18});
      exp_q.push_back('{4'b0010, 8'h24});
      exp_q.push_back('{4'b0100, 8'h42});
      exp_q.push_back('{4'b1000, 8'h81});
      exp_q.push_back('{4'b0001, 8'h18});
      bus.REQ = 4'b1111;
      n = 0;
      pg = '0;
      for (int i = 0; i < 400 && n < 5; i++) begin
         step();
         if (bus.GNT != 0 && pg == 0) n++;
         pg = bus.GNT;
      end
      chk("contend_grants", 32'(n), 32'd5);
      bus.REQ = '0;
      wait_idle(200);

      // Single request, 0xA5
      chk("idle_gnt", 32'(bus.GNT), 32'h0);
      bus.PAT = 32'h0000_00A5;
      bus.REQ = 4'b0001;
      exp_q.push_back('{4'b0001, 8'hA5});
      step();
      chk("single_gnt", 32'(bus.GNT), 32'h1);
      chk("single_busy", 32'(bus.BUSY), 32'h1);
      bus.REQ = '0;
      wait_idle(100);

      // Grant 2 with 0xFF, then PAT and REQ drop mid-play
      bus.PAT = 32'h00FF_0000;
      bus.REQ = 4'b0100;
      exp_q.push_back('{4'b0100, 8'hFF});
      step();
      chk("p2_gnt", 32'(bus.GNT), 32'h4);
      repeat (5) step();
      bus.PAT = '0;
      bus.REQ = '0;
      wait_idle(100);

      // Zero pattern still plays 8 ticks
      bus.PAT = 32'h0;
      bus.REQ = 4'b0010;
      exp_q.push_back('{4'b0010, 8'h00});
      step();
      chk("zero_gnt", 32'(bus.GNT), 32'h2);
      bus.REQ = '0;
      wait_idle(100);

      // Reset mid-play: no DONE, then re-arbitrate
      bus.PAT = 32'h0000_003C;
      bus.REQ = 4'b0001;
      step();
      chk("rp_gnt", 32'(bus.GNT), 32'h1);
      bus.REQ = '0;
      repeat (10) step();
      RST_N = 1'b0;
      #1;
      chk("rp_led", 32'(bus.LED), 32'h0);
      chk("rp_gnt0", 32'(bus.GNT), 32'h0);
      chk("rp_busy", 32'(bus.BUSY), 32'h0);
      chk("rp_done", 32'(bus.DONE), 32'h0);
      step();
      bus.PAT = 32'h9600_0000;
      bus.REQ = 4'b1000;
      step();
      RST_N = 1'b1;
      exp_q.push_back('{4'b1000, 8'h96});
      step();
      chk("rp_regnt", 32'(bus.GNT), 32'h8);
      bus.REQ = '0;
      wait_idle(100);
      repeat (4) step();

      chk("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
